// File: rtl/myc64_prg_loader.sv
// Streams a C64 .PRG byte stream into RAM via the myc64_top ext write port.
// Parses the load-address header and optionally patches VARTAB afterwards.
module myc64_prg_loader #(
  parameter bit SET_VARTAB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  input  logic        i_byte_last,
  output logic        o_byte_ready,
  output logic        o_ext_we,
  output logic [15:0] o_ext_addr,
  output logic [7:0]  o_ext_data,
  input  logic        i_ext_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_load_addr,
  output logic [15:0] o_end_addr
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA_WAIT,
    DATA_WR,
    VT_LO,
    VT_HI,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [15:0] ptr, ptr_n, ptr_inc;
  logic [15:0] ea_n, load_n, end_n;
  logic [7:0]  ed_n;
  logic        last_q, last_n, err_n;
  logic        xfer;

  assign xfer    = i_byte_valid & o_byte_ready;
  assign ptr_inc = ptr + 16'd1;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    ea_n    = o_ext_addr;
    ed_n    = o_ext_data;
    load_n  = o_load_addr;
    end_n   = o_end_addr;
    last_n  = last_q;
    err_n   = o_error;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_n = HDR_LO;
          err_n   = 1'b0;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          load_n[7:0] = i_byte_data;
          if (i_byte_last) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = HDR_HI;
          end
        end
      end
      HDR_HI: begin
        if (xfer) begin
          load_n[15:8] = i_byte_data;
          ptr_n        = {i_byte_data, o_load_addr[7:0]};
          if (i_byte_last) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = DATA_WAIT;
          end
        end
      end
      DATA_WAIT: begin
        if (xfer) begin
          ea_n    = ptr;
          ed_n    = i_byte_data;
          last_n  = i_byte_last;
          state_n = DATA_WR;
        end
      end
      DATA_WR: begin
        if (i_ext_ready) begin
          ptr_n = ptr_inc;
          end_n = ptr_inc;
          if (last_q) begin
            if (SET_VARTAB) begin
              ea_n    = 16'h002D;
              ed_n    = ptr_inc[7:0];
              state_n = VT_LO;
            end else begin
              state_n = DONE;
            end
          end else if (ptr == 16'hFFFF) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = DATA_WAIT;
          end
        end
      end
      VT_LO: begin
        if (i_ext_ready) begin
          ea_n    = 16'h002E;
          ed_n    = o_end_addr[15:8];
          state_n = VT_HI;
        end
      end
      VT_HI: begin
        if (i_ext_ready) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Status flags are registered from the next state, not decoded from state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      last_q       <= 1'b0;
      o_byte_ready <= 1'b0;
      o_ext_we     <= 1'b0;
      o_ext_addr   <= '0;
      o_ext_data   <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_load_addr  <= '0;
      o_end_addr   <= '0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      last_q       <= last_n;
      o_byte_ready <= (state_n == HDR_LO) || (state_n == HDR_HI) ||
                      (state_n == DATA_WAIT);
      o_ext_we     <= (state_n == DATA_WR) || (state_n == VT_LO) ||
                      (state_n == VT_HI);
      o_ext_addr   <= ea_n;
      o_ext_data   <= ed_n;
      o_busy       <= (state_n != IDLE);
      o_done       <= (state_n == DONE);
      o_error      <= err_n;
      o_load_addr  <= load_n;
      o_end_addr   <= end_n;
    end
  end

endmodule
